// File: rtl/fpu_pkg.sv
// Shared definitions for the fixed-point unit issue path: opcodes,
// response error codes, issuer FSM states and the opcode legality check.
package fpu_pkg;

  localparam logic [3:0] FPU_OP_ADD   = 4'b0000;
  localparam logic [3:0] FPU_OP_SUB   = 4'b0001;
  localparam logic [3:0] FPU_OP_MUL   = 4'b0010;
  localparam logic [3:0] FPU_OP_DIV   = 4'b0011;
  localparam logic [3:0] FPU_OP_SGNJ  = 4'b0100;
  localparam logic [3:0] FPU_OP_SGNJN = 4'b0101;
  localparam logic [3:0] FPU_OP_SGNJX = 4'b0110;
  localparam logic [3:0] FPU_OP_EQ    = 4'b1001;
  localparam logic [3:0] FPU_OP_LT    = 4'b1010;
  localparam logic [3:0] FPU_OP_LE    = 4'b1011;
  localparam logic [3:0] FPU_OP_MIN   = 4'b1100;
  localparam logic [3:0] FPU_OP_MAX   = 4'b1101;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_INVOP   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_EXEC       = 3'd1,
    ST_DIV_LAUNCH = 3'd2,
    ST_DIV_WAIT   = 3'd3,
    ST_RESP       = 3'd4
  } fpu_state_e;

  // True for every opcode the unit implements; unused codes are rejected
  // before anything is driven to the unit.
  function automatic logic fpu_op_valid(input logic [3:0] op);
    logic ok;
    case (op)
      FPU_OP_ADD, FPU_OP_SUB, FPU_OP_MUL, FPU_OP_DIV,
      FPU_OP_SGNJ, FPU_OP_SGNJN, FPU_OP_SGNJX,
      FPU_OP_EQ, FPU_OP_LT, FPU_OP_LE, FPU_OP_MIN, FPU_OP_MAX: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fpu_issuer_if.sv
// Bundle of the request handshake, response handshake and unit-side bus.
// master = the issuer, slave = the core/unit environment around it.
interface fpu_issuer_if #(parameter int TAG_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [63:0]      req_a;
  logic [63:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       rsp_err;
  logic [3:0]       fpu_op;
  logic [63:0]      fpu_a;
  logic [63:0]      fpu_b;
  logic             fpu_busy;
  logic [63:0]      fpu_res;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready, fpu_busy, fpu_res,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, fpu_op, fpu_a, fpu_b
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready, fpu_busy, fpu_res,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, fpu_op, fpu_a, fpu_b
  );
endinterface

// File: rtl/fpu_issuer.sv
// Issues one operation at a time to the fixed-point unit, holds the operands
// for multi-cycle divides, and returns the captured result with its tag.
module fpu_issuer
  import fpu_pkg::*;
#(
  parameter int         TAG_W       = 5,
  parameter int         DIV_TIMEOUT = 128,
  parameter logic [3:0] IDLE_OP     = 4'b0000
) (
  input logic          clk,
  input logic          reset,
  fpu_issuer_if.master bus
);

  localparam int CNT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  fpu_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       op_r, op_s;
  logic [63:0]      a_r, a_s, b_r, b_s;
  logic             rsp_valid_r;
  logic [63:0]      rsp_data_r, rsp_data_s;
  logic [TAG_W-1:0] rsp_tag_r, rsp_tag_s;
  logic [1:0]       rsp_err_r, rsp_err_s;
  logic [3:0]       fpu_op_r, fpu_op_s;
  logic [63:0]      fpu_a_r, fpu_a_s, fpu_b_r, fpu_b_s;
  logic             req_ready_s, accept_s, drive_s;

  // Reset is folded in so nothing is accepted in the reset cycle itself.
  assign req_ready_s = !reset && (state_r == ST_IDLE) && !bus.fpu_busy;
  assign accept_s    = bus.req_valid && req_ready_s;

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_tag   = rsp_tag_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.fpu_op    = fpu_op_r;
  assign bus.fpu_a     = fpu_a_r;
  assign bus.fpu_b     = fpu_b_r;

  // Next state, latched request, response payload and next unit drive.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    op_s       = op_r;
    a_s        = a_r;
    b_s        = b_r;
    rsp_data_s = rsp_data_r;
    rsp_tag_s  = rsp_tag_r;
    rsp_err_s  = rsp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          op_s      = bus.req_op;
          a_s       = bus.req_a;
          b_s       = bus.req_b;
          rsp_tag_s = bus.req_tag;
          if (!fpu_op_valid(bus.req_op)) begin
            rsp_data_s = 64'd0;
            rsp_err_s  = ERR_INVOP;
            state_s    = ST_RESP;
          end else if (bus.req_op == FPU_OP_DIV) begin
            state_s = ST_DIV_LAUNCH;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_data_s = bus.fpu_res;
        rsp_err_s  = ERR_OK;
        state_s    = ST_RESP;
      end
      ST_DIV_LAUNCH: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = ST_DIV_WAIT;
      end
      ST_DIV_WAIT: begin
        // Completion wins over timeout when both land in the same cycle.
        if (!bus.fpu_busy) begin
          rsp_data_s = bus.fpu_res;
          rsp_err_s  = ERR_OK;
          state_s    = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          rsp_data_s = 64'd0;
          rsp_err_s  = ERR_TIMEOUT;
          state_s    = ST_RESP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // The unit only sees the request while it is actually executing.
    drive_s = (state_s == ST_EXEC) || (state_s == ST_DIV_LAUNCH) || (state_s == ST_DIV_WAIT);
    if (drive_s) begin
      fpu_op_s = op_s;
      fpu_a_s  = a_s;
      fpu_b_s  = b_s;
    end else begin
      fpu_op_s = IDLE_OP;
      fpu_a_s  = 64'd0;
      fpu_b_s  = 64'd0;
    end
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      op_r        <= IDLE_OP;
      a_r         <= 64'd0;
      b_r         <= 64'd0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 64'd0;
      rsp_tag_r   <= {TAG_W{1'b0}};
      rsp_err_r   <= ERR_OK;
      fpu_op_r    <= IDLE_OP;
      fpu_a_r     <= 64'd0;
      fpu_b_r     <= 64'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      op_r        <= op_s;
      a_r         <= a_s;
      b_r         <= b_s;
      rsp_valid_r <= (state_s == ST_RESP);
      rsp_data_r  <= rsp_data_s;
      rsp_tag_r   <= rsp_tag_s;
      rsp_err_r   <= rsp_err_s;
      fpu_op_r    <= fpu_op_s;
      fpu_a_r     <= fpu_a_s;
      fpu_b_r     <= fpu_b_s;
    end
  end

endmodule

// File: tb/tb_fpu_issuer.sv
// Scoreboard bench for fpu_issuer: a behavioural unit stub with a 20-cycle
// divider, plus a second instance with a short timeout and a stuck divider.
module tb_fpu_issuer;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_issuer_if #(.TAG_W(5)) ifm ();
  fpu_issuer_if #(.TAG_W(5)) ift ();

  fpu_issuer #(.TAG_W(5), .DIV_TIMEOUT(128), .IDLE_OP(4'b0000)) dut (
    .clk(clk), .reset(reset), .bus(ifm));
  fpu_issuer #(.TAG_W(5), .DIV_TIMEOUT(16), .IDLE_OP(4'b0000)) dut_to (
    .clk(clk), .reset(reset), .bus(ift));

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Unit stub for the main instance: combinational results, 20-cycle divider.
  int div_cnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      ifm.fpu_busy <= 1'b0;
      div_cnt <= 0;
    end else if (ifm.fpu_busy) begin
      if (div_cnt == 1) ifm.fpu_busy <= 1'b0;
      div_cnt <= div_cnt - 1;
    end else if (ifm.fpu_op == FPU_OP_DIV) begin
      ifm.fpu_busy <= 1'b1;
      div_cnt <= 20;
    end
  end

  always_comb begin
    case (ifm.fpu_op)
      FPU_OP_ADD: ifm.fpu_res = ifm.fpu_a + ifm.fpu_b;
      FPU_OP_SUB: ifm.fpu_res = ifm.fpu_a - ifm.fpu_b;
      FPU_OP_LT:  ifm.fpu_res = ($signed(ifm.fpu_a) <  $signed(ifm.fpu_b)) ? 64'd1 : 64'd0;
      FPU_OP_LE:  ifm.fpu_res = ($signed(ifm.fpu_a) <= $signed(ifm.fpu_b)) ? 64'd1 : 64'd0;
      FPU_OP_MIN: ifm.fpu_res = ($signed(ifm.fpu_a) <  $signed(ifm.fpu_b)) ? ifm.fpu_a : ifm.fpu_b;
      FPU_OP_MAX: ifm.fpu_res = ($signed(ifm.fpu_a) >  $signed(ifm.fpu_b)) ? ifm.fpu_a : ifm.fpu_b;
      FPU_OP_DIV: ifm.fpu_res = 64'h1234;
      default:    ifm.fpu_res = 64'd0;
    endcase
  end

  // Stub for the timeout instance: once a divide launches, busy never drops.
  always @(posedge clk) begin
    if (reset) ift.fpu_busy <= 1'b0;
    else if (ift.fpu_op == FPU_OP_DIV) ift.fpu_busy <= 1'b1;
  end
  assign ift.fpu_res = 64'hDEAD_BEEF_0000_0001;

  // Response monitor: pops the scoreboard on every handshake.
  logic prev_v = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (ifm.rsp_valid && !prev_v) rise_cyc = cyc;
      if (ifm.rsp_valid && ifm.rsp_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_data", ifm.rsp_data, e.data);
          chk("rsp_tag", 64'(ifm.rsp_tag), 64'(e.tag));
          chk("rsp_err", 64'(ifm.rsp_err), 64'(e.err));
          if (e.lat != 0) chk("rsp_latency", 64'(rise_cyc - e.acc), 64'(e.lat));
        end
      end
      prev_v = ifm.rsp_valid;
    end
  end

  // Drive one request on the main instance and push its expected response.
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] tag, input logic [63:0] ed, input logic [1:0] ee,
                      input int lat, output int nwait);
    exp_t e;
    nwait = 0;
    @(posedge clk); #1;
    ifm.req_op = op; ifm.req_a = a; ifm.req_b = b; ifm.req_tag = tag;
    ifm.req_valid = 1'b1;
    @(negedge clk);
    while (!ifm.req_ready && nwait < 200) begin
      @(negedge clk);
      nwait++;
    end
    if (!ifm.req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      e.data = ed; e.tag = tag; e.err = ee; e.lat = lat; e.acc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    ifm.req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int nw, k, divc, acc;
    logic saw_busy;
    logic [63:0] hd;
    logic [4:0]  ht;
    logic [1:0]  he;

    ifm.req_valid = 1'b0; ifm.req_op = 4'd0; ifm.req_a = 64'd0; ifm.req_b = 64'd0;
    ifm.req_tag = 5'd0; ifm.rsp_ready = 1'b1;
    ift.req_valid = 1'b0; ift.req_op = 4'd0; ift.req_a = 64'd0; ift.req_b = 64'd0;
    ift.req_tag = 5'd0; ift.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(ifm.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(ifm.rsp_valid), 64'd0);
    chk("rst_rsp_data", ifm.rsp_data, 64'd0);
    chk("rst_rsp_tag", 64'(ifm.rsp_tag), 64'd0);
    chk("rst_rsp_err", 64'(ifm.rsp_err), 64'd0);
    chk("rst_fpu_op", 64'(ifm.fpu_op), 64'd0);
    chk("rst_fpu_a", ifm.fpu_a, 64'd0);
    chk("rst_fpu_b", ifm.fpu_b, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(ifm.req_ready), 64'd1);

    // 1: ADD
    send(FPU_OP_ADD, 64'h0001_0000, 64'h0002_0000, 5'd3, 64'h0003_0000, ERR_OK, 2, nw);
    drain();

    // 2: compare and select
    send(FPU_OP_LT, -64'sd1, 64'sd2, 5'd4, 64'd1, ERR_OK, 2, nw);
    send(FPU_OP_LE, 64'sd2, 64'sd2, 5'd5, 64'd1, ERR_OK, 2, nw);
    send(FPU_OP_MIN, -64'sd5, 64'sd7, 5'd6, 64'hFFFF_FFFF_FFFF_FFFB, ERR_OK, 2, nw);
    send(FPU_OP_MAX, -64'sd5, 64'sd7, 5'd7, 64'd7, ERR_OK, 2, nw);
    drain();

    // 3: DIV with 20-cycle busy; operands held stable the whole time
    send(FPU_OP_DIV, 64'd100, 64'd5, 5'd8, 64'h1234, ERR_OK, 0, nw);
    k = 0; saw_busy = 1'b0;
    while (!ifm.rsp_valid && k < 60) begin
      @(negedge clk);
      k++;
      if (!ifm.rsp_valid) begin
        chk("div_fpu_op", 64'(ifm.fpu_op), 64'(FPU_OP_DIV));
        chk("div_fpu_a", ifm.fpu_a, 64'd100);
        chk("div_fpu_b", ifm.fpu_b, 64'd5);
        chk("div_req_ready", 64'(ifm.req_ready), 64'd0);
        if (ifm.fpu_busy) saw_busy = 1'b1;
      end
    end
    chk("div_saw_busy", 64'(saw_busy), 64'd1);
    drain();

    // 4: invalid opcode never reaches the unit
    send(4'b0111, 64'd11, 64'd22, 5'd9, 64'd0, ERR_INVOP, 1, nw);
    for (int i = 0; i < 3; i++) begin
      chk("inv_fpu_op", 64'(ifm.fpu_op), 64'd0);
      @(negedge clk);
    end
    drain();

    // 5: backpressure, then back-to-back accept after the handshake
    @(posedge clk); #1 ifm.rsp_ready = 1'b0;
    send(FPU_OP_SUB, 64'd50, 64'd8, 5'd10, 64'd42, ERR_OK, 2, nw);
    k = 0;
    while (!ifm.rsp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("bp_rsp_valid", 64'(ifm.rsp_valid), 64'd1);
    hd = ifm.rsp_data; ht = ifm.rsp_tag; he = ifm.rsp_err;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 64'(ifm.rsp_valid), 64'd1);
      chk("bp_data_held", ifm.rsp_data, hd);
      chk("bp_tag_held", 64'(ifm.rsp_tag), 64'(ht));
      chk("bp_err_held", 64'(ifm.rsp_err), 64'(he));
      chk("bp_req_ready", 64'(ifm.req_ready), 64'd0);
    end
    @(posedge clk); #1 ifm.rsp_ready = 1'b1;
    send(FPU_OP_ADD, 64'd1, 64'd2, 5'd11, 64'd3, ERR_OK, 2, nw);
    chk("bp_next_accept_wait", 64'(nw), 64'd0);
    drain();

    // 6a: divide timeout on the short-timeout instance
    while (ifm.fpu_busy && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    ift.req_op = FPU_OP_DIV; ift.req_a = 64'd9; ift.req_b = 64'd3; ift.req_tag = 5'd12;
    ift.req_valid = 1'b1;
    @(negedge clk);
    chk("to_req_ready", 64'(ift.req_ready), 64'd1);
    acc = cyc;
    @(posedge clk); #1 ift.req_valid = 1'b0;
    k = 0; divc = 0;
    while (!ift.rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
      if (ift.fpu_op == FPU_OP_DIV) divc++;
    end
    chk("to_rsp_valid", 64'(ift.rsp_valid), 64'd1);
    chk("to_div_cycles", 64'(divc), 64'd17);
    chk("to_latency", 64'(cyc - acc), 64'd18);
    chk("to_rsp_err", 64'(ift.rsp_err), 64'(ERR_TIMEOUT));
    chk("to_rsp_data", ift.rsp_data, 64'd0);
    chk("to_rsp_tag", 64'(ift.rsp_tag), 64'd12);
    @(negedge clk);
    chk("to_rsp_drop", 64'(ift.rsp_valid), 64'd0);

    // 6b: reset in the middle of a divide wait
    send(FPU_OP_DIV, 64'd70, 64'd7, 5'd13, 64'h1234, ERR_OK, 0, nw);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("pre_rst_fpu_op", 64'(ifm.fpu_op), 64'(FPU_OP_DIV));
    @(negedge clk);
    chk("mid_rst_rsp_valid", 64'(ifm.rsp_valid), 64'd0);
    chk("mid_rst_fpu_op", 64'(ifm.fpu_op), 64'd0);
    chk("mid_rst_fpu_a", ifm.fpu_a, 64'd0);
    chk("mid_rst_req_ready", 64'(ifm.req_ready), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(ifm.req_ready), 64'd1);
    repeat (30) @(negedge clk);
    send(FPU_OP_ADD, 64'd5, 64'd6, 5'd14, 64'd11, ERR_OK, 2, nw);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_issuer.md
Name: fpu_issuer

Overview:
Initiator side of the fixed-point unit interface. It accepts one operation request at a time from the core's execute stage over a valid/ready handshake. It drives opcode and operands to the fixed-point unit and holds them stable for multi-cycle divides. It captures the result and returns it, with the request tag and an error code, over a second valid/ready handshake.

Parameters:
TAG_W, 5, width of the request/response tag (destination register id).
DIV_TIMEOUT, 128, maximum DIV_WAIT cycles before the divide is abandoned with an error.
IDLE_OP, 4'b0000, opcode driven to the FPU when no operation is in flight.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when high with req_valid.
req_op  in  4  FPU opcode.
req_a  in  64  signed fixed-point operand A.
req_b  in  64  signed fixed-point operand B.
req_tag  in  TAG_W  returned unchanged with the response.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_data  out  64  result.
rsp_tag  out  TAG_W  tag of the completed request.
rsp_err  out  2  00 ok, 01 invalid opcode, 10 divide timeout.
fpu_op  out  4  opcode to the FPU.
fpu_a  out  64  operand A to the FPU.
fpu_b  out  64  operand B to the FPU.
fpu_busy  in  1  FPU divider busy.
fpu_res  in  64  FPU result (combinational from fpu_op/fpu_a/fpu_b, except divide).

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset state: state=IDLE, wait counter=0.
- Reset outputs: rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=00, fpu_op=IDLE_OP, fpu_a=0, fpu_b=0. req_ready=0 during the reset cycle.
- Reset mid-operation: any state returns to IDLE on the next edge. The in-flight result is discarded and no response is emitted.
- Valid opcodes: 0000–0110, 1001, 1010, 1011, 1100, 1101. All others are invalid.
- Opcode 0011 is DIV; every other valid opcode is single-cycle.
- req_ready = (state==IDLE) && !fpu_busy.
- Accept: on req_valid && req_ready, latch op, a, b and tag into internal registers.
- FPU drive: fpu_op, fpu_a and fpu_b carry the latched values only in EXEC, DIV_LAUNCH and DIV_WAIT. In every other state they carry IDLE_OP, 0 and 0.
- IDLE: on accept,
  - invalid opcode → RESP with rsp_err=01, rsp_data=0; the FPU is never driven;
  - DIV → DIV_LAUNCH;
  - otherwise → EXEC.
- EXEC: one cycle; register fpu_res into rsp_data, rsp_err=00 → RESP. Latency: accept at cycle N, rsp_valid high at N+2.
- DIV_LAUNCH: one cycle with fpu_op=0011 and fpu_busy low, which launches the divide → DIV_WAIT with counter cleared.
- DIV_WAIT: hold fpu_op=0011 and operands; the counter increments each cycle.
  - fpu_busy==0 → capture fpu_res, rsp_err=00 → RESP.
  - Otherwise, counter==DIV_TIMEOUT-1 → rsp_data=0, rsp_err=10 → RESP.
  - busy-low is checked before timeout when both occur in the same cycle.
- Capture-cycle relaunch: on the capture cycle the divider may relaunch because fpu_op is still 0011 and busy is low. This is tolerated and the result of the relaunch is ignored. The next request waits on fpu_busy through req_ready.
- RESP: rsp_valid=1; rsp_data, rsp_tag and rsp_err held stable until rsp_ready. On handshake → IDLE, and rsp_valid falls on the next cycle.
  - rsp_ready already high when rsp_valid rises completes that same cycle.
- Throughput: no request is accepted in RESP, so the best-case throughput is one op per 3 cycles.
- Width: operands and results pass through unmodified as 64-bit signed values. The block performs no arithmetic beyond the 0-to-(DIV_TIMEOUT-1) wait counter.

Decomposition:
- Shared package fpu_pkg:
  - opcode localparams FPU_OP_ADD, SUB, MUL, DIV, SGNJ, SGNJN, SGNJX, EQ, LT, LE, MIN, MAX;
  - rsp_err codes ERR_OK, ERR_INVOP, ERR_TIMEOUT;
  - state encoding IDLE, EXEC, DIV_LAUNCH, DIV_WAIT, RESP;
  - function fpu_op_valid(op).
- No sub-module: one FSM plus operand and response registers.

Test Plan:
1. ADD: op 0000, a=64'h0001_0000, b=64'h0002_0000, tag=3, rsp_ready=1 → rsp_valid at accept+2; rsp_data=64'h0003_0000, tag 3, err 00.
2. Compare and select in sequence: LT a=-1 b=2 → 1; LE a=2 b=2 → 1; MIN a=-5 b=7 → -5; MAX a=-5 b=7 → 7. Each response returns its own tag.
3. DIV against an FPU stub holding busy for 20 cycles then res=64'h1234 → fpu_op=0011 and operands stable across DIV_LAUNCH and DIV_WAIT; rsp_data=64'h1234, err 00; req_ready low while stub busy.
4. Invalid op 4'b0111, tag=9 → rsp_valid at accept+1, rsp_err=01, rsp_data=0; fpu_op stays IDLE_OP throughout.
5. Backpressure: rsp_ready low for 5 cycles after rsp_valid → data, tag and err unchanged; req_ready=0; a new request is accepted in the cycle after the handshake.
6. Timeout and reset:
   - DIV_TIMEOUT=16 with stub busy stuck high → rsp_err=10, rsp_data=0 after 16 DIV_WAIT cycles.
   - Reset asserted mid-DIV_WAIT → state IDLE, rsp_valid=0, fpu_op=IDLE_OP on the next cycle.
